// File: rtl/interval_timer.sv
// Interval timer for IR mark/space timing: unit prescaler, delay countdown, auto-reload, pause,
// abort and expiry pulse. Define INTERVAL_TIMER_SHADOW_EN to queue a next delay while busy.
module interval_timer #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned UNIT_COUNTS_US = 10,
    parameter int unsigned CLK_MHZ        = 8
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             enable_in,
    input  logic             abort_in,
    input  logic             periodic_in,
    input  logic [WIDTH-1:0] delay_in,
    input  logic             update_delay_in,
    output logic             busy_out,
    output logic             expired_out,
    output logic [WIDTH-1:0] remaining_out,
    output logic             queue_full_out
);

    localparam int unsigned CPU = CLK_MHZ * UNIT_COUNTS_US;
    localparam int unsigned UW  = $clog2(CPU);
    localparam logic [UW-1:0]    UnitMax = UW'(CPU - 1);
    localparam logic [WIDTH-1:0] OneUnit = WIDTH'(1);

    logic [WIDTH-1:0] delay_q, delay_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [UW-1:0]    unit_q, unit_d;
    logic             expired_q, expired_d;
    logic             busy;
    logic             terminal;

`ifdef INTERVAL_TIMER_SHADOW_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             shadow_valid_q, shadow_valid_d;
`endif

    assign busy     = (delay_q != '0);
    assign terminal = busy && enable_in && (unit_q == '0) && (delay_q == OneUnit);

    always_comb begin
        delay_d   = delay_q;
        reload_d  = reload_q;
        unit_d    = unit_q;
        expired_d = 1'b0;
`ifdef INTERVAL_TIMER_SHADOW_EN
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
`endif
        if (abort_in) begin
            delay_d = '0;
            unit_d  = UnitMax;
`ifdef INTERVAL_TIMER_SHADOW_EN
            shadow_valid_d = 1'b0;
`endif
        end else if (terminal) begin
            expired_d = 1'b1;
            unit_d    = UnitMax;
`ifdef INTERVAL_TIMER_SHADOW_EN
            // A write landing on the terminal tick wins over both queue and reload.
            if (update_delay_in) begin
                delay_d        = delay_in;
                reload_d       = delay_in;
                shadow_valid_d = 1'b0;
            end else if (shadow_valid_q) begin
                delay_d        = shadow_q;
                reload_d       = shadow_q;
                shadow_valid_d = 1'b0;
            end else if (periodic_in) begin
                delay_d = reload_q;
            end else begin
                delay_d = '0;
            end
`else
            delay_d = periodic_in ? reload_q : '0;
`endif
        end else begin
            if (busy && enable_in) begin
                if (unit_q == '0) begin
                    unit_d  = UnitMax;
                    delay_d = delay_q - OneUnit;
                end else begin
                    unit_d = unit_q - 1'b1;
                end
            end
            if (update_delay_in) begin
                if (!busy) begin
                    if (delay_in != '0) begin
                        delay_d  = delay_in;
                        reload_d = delay_in;
                        unit_d   = UnitMax;
                    end
                end else begin
`ifdef INTERVAL_TIMER_SHADOW_EN
                    shadow_d       = delay_in;
                    shadow_valid_d = 1'b1;
`endif
                end
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            delay_q   <= '0;
            reload_q  <= '0;
            unit_q    <= UnitMax;
            expired_q <= 1'b0;
        end else begin
            delay_q   <= delay_d;
            reload_q  <= reload_d;
            unit_q    <= unit_d;
            expired_q <= expired_d;
        end
    end

`ifdef INTERVAL_TIMER_SHADOW_EN
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end

    assign queue_full_out = shadow_valid_q;
`else
    assign queue_full_out = 1'b0;
`endif

    assign busy_out      = busy;
    assign expired_out   = expired_q;
    assign remaining_out = delay_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with CPU=2 (CLK_MHZ=2, UNIT_COUNTS_US=1): a vector table
// for plain loads and abort, hand-written sequences for periodic, pause, queue and reset.
module tb_interval_timer;

    logic        clk = 1'b0;
    logic        reset_in, enable_in, abort_in, periodic_in, update_delay_in;
    logic [15:0] delay_in;
    logic        busy_out, expired_out, queue_full_out;
    logic [15:0] remaining_out;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    interval_timer #(
        .WIDTH         (16),
        .UNIT_COUNTS_US(1),
        .CLK_MHZ       (2)
    ) dut (
        .clock_in       (clk),
        .reset_in       (reset_in),
        .enable_in      (enable_in),
        .abort_in       (abort_in),
        .periodic_in    (periodic_in),
        .delay_in       (delay_in),
        .update_delay_in(update_delay_in),
        .busy_out       (busy_out),
        .expired_out    (expired_out),
        .remaining_out  (remaining_out),
        .queue_full_out (queue_full_out)
    );

    typedef struct packed {
        logic        ab;
        logic        upd;
        logic [15:0] dly;
        logic        busy;
        logic        exp;
        logic [15:0] rem;
    } vec_t;

    vec_t vecs [20];

    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, want, edge_cnt);
        end
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        step();
        step();
        reset_in = 1'b0;
    endtask

    initial begin
        int e0;
        int found;
        // Test 1: load 3; test 4: load 5 then abort+update on the 4th edge, no expiry ever.
        vecs[0]  = '{1'b0, 1'b1, 16'd3, 1'b1, 1'b0, 16'd3};
        vecs[1]  = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd3};
        vecs[2]  = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd2};
        vecs[3]  = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd2};
        vecs[4]  = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd1};
        vecs[5]  = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd1};
        vecs[6]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd0};
        vecs[7]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0};
        vecs[8]  = '{1'b0, 1'b1, 16'd5, 1'b1, 1'b0, 16'd5};
        vecs[9]  = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd5};
        vecs[10] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd4};
        vecs[11] = '{1'b1, 1'b1, 16'd7, 1'b0, 1'b0, 16'd0};
        for (int i = 12; i < 20; i++) vecs[i] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0};

        enable_in = 1'b1; abort_in = 1'b0; periodic_in = 1'b0;
        update_delay_in = 1'b0; delay_in = '0;
        do_reset();
        check("reset_busy", busy_out, 0);
        check("reset_expired", expired_out, 0);
        check("reset_remaining", remaining_out, 0);
        check("reset_qfull", queue_full_out, 0);

        for (int i = 0; i < 20; i++) begin
            abort_in        = vecs[i].ab;
            update_delay_in = vecs[i].upd;
            delay_in        = vecs[i].dly;
            step();
            check($sformatf("vec%0d_busy", i), busy_out, vecs[i].busy);
            check($sformatf("vec%0d_expired", i), expired_out, vecs[i].exp);
            check($sformatf("vec%0d_remaining", i), remaining_out, vecs[i].rem);
        end
        abort_in = 1'b0; update_delay_in = 1'b0;

        // Test 2: periodic load 2 -> expiry every 4 edges, busy continuous.
        do_reset();
        periodic_in = 1'b1; update_delay_in = 1'b1; delay_in = 16'd2;
        step();
        update_delay_in = 1'b0;
        e0 = edge_cnt;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("per_busy_%0d", k), busy_out, 1);
            check($sformatf("per_expired_%0d", k), expired_out, (k % 4 == 0) ? 1 : 0);
        end
        periodic_in = 1'b0;
        for (int k = 13; k <= 16; k++) step();
        check("per_drop_expired", expired_out, 1);
        check("per_drop_busy", busy_out, 0);

        // Test 3: load 4, pause 5 cycles after 2 edges -> expiry at edge 13 after load.
        do_reset();
        update_delay_in = 1'b1; delay_in = 16'd4;
        step();
        update_delay_in = 1'b0;
        e0 = edge_cnt;
        step(); step();
        enable_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("pause_rem_%0d", k), remaining_out, 3);
        end
        enable_in = 1'b1;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            step();
            if (expired_out) found = edge_cnt - e0;
        end
        check("pause_expiry_edge", found, 13);

        // Test 5: load 2, queue 5 on next edge.
        do_reset();
        update_delay_in = 1'b1; delay_in = 16'd2;
        step();
        delay_in = 16'd5;
        step();
        update_delay_in = 1'b0; delay_in = '0;
`ifdef INTERVAL_TIMER_SHADOW_EN
        check("queue_full", queue_full_out, 1);
`else
        check("queue_full", queue_full_out, 0);
`endif
        step(); step(); step();
        check("queue_expired", expired_out, 1);
`ifdef INTERVAL_TIMER_SHADOW_EN
        check("queue_remaining", remaining_out, 5);
        check("queue_busy", busy_out, 1);
        check("queue_full_after", queue_full_out, 0);
        for (int k = 5; k < 14; k++) begin
            step();
            check($sformatf("queue_busy_%0d", k), busy_out, 1);
        end
        step();
        check("queue_idle_busy", busy_out, 0);
        check("queue_idle_expired", expired_out, 1);
`else
        check("noqueue_remaining", remaining_out, 0);
        check("noqueue_busy", busy_out, 0);
`endif

        // Test 6: reset mid periodic count, then a zero update stays idle.
        do_reset();
        periodic_in = 1'b1; update_delay_in = 1'b1; delay_in = 16'd3;
        step();
        update_delay_in = 1'b0;
        step(); step(); step();
        check("pre_reset_busy", busy_out, 1);
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        check("rst_busy", busy_out, 0);
        check("rst_expired", expired_out, 0);
        check("rst_remaining", remaining_out, 0);
        check("rst_qfull", queue_full_out, 0);
        update_delay_in = 1'b1; delay_in = 16'd0;
        step();
        update_delay_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("zero_load_busy_%0d", k), busy_out, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
